// File: rtl/fu_alu_queue_pkg.sv
// Shared definitions for the FU-stage ALU command queue: FSM state encodings and CSR bit indices.
package fu_alu_queue_pkg;

  // Bit positions shared by alu_csr_in and alu_csr_out.
  localparam int FU_CSR_PROT = 0;
  localparam int FU_CSR_OP1  = 1;
  localparam int FU_CSR_OP2  = 2;
  // On alu_csr_out, bit 2 carries the ALU "result valid" flag.
  localparam int FU_CSR_RES  = FU_CSR_OP2;

  localparam logic [2:0] FU_CSR_IN_IDLE = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_W_OP1   = 3'd1,
    S_L_OP1   = 3'd2,
    S_W_OP2   = 3'd3,
    S_L_OP2   = 3'd4,
    S_COMPUTE = 3'd5,
    S_RELEASE = 3'd6
  } fu_state_e;

endpackage

// File: rtl/fu_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers; head reads 0 while empty.
module fu_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty    = (wr_ptr == rd_ptr);
  assign count    = wr_ptr - rd_ptr;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is data only and is never reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fu_alu_queue.sv
// Queued front-end for the external FU-stage ALU: command FIFO, CSR handshake FSM, result FIFO.
// Optional watchdog on the ALU handshake is enabled by defining FU_ALU_TIMEOUT_EN.
module fu_alu_queue
  import fu_alu_queue_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ALUOP_W   = 4,
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 2,
  parameter int TMO_CYC   = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ALUOP_W-1:0]         req_aluop,
  input  logic [DATA_W-1:0]          req_op1,
  input  logic [DATA_W-1:0]          req_op2,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_err,
  output logic [ALUOP_W-1:0]         alu_aluop,
  output logic [DATA_W-1:0]          alu_op1,
  output logic [DATA_W-1:0]          alu_op2,
  input  logic [DATA_W-1:0]          alu_op3,
  input  logic [2:0]                 alu_csr_out,
  output logic [2:0]                 alu_csr_in,
  output logic                       busy,
  output logic [$clog2(CMD_DEPTH):0] cmd_count
);

  localparam int CMD_W = ALUOP_W + 2 * DATA_W;

  fu_state_e                  state;
  logic [2:0]                 csr_in;
  logic                       cmd_push;
  logic                       cmd_pop;
  logic                       cmd_full;
  logic                       cmd_empty;
  logic [CMD_W-1:0]           cmd_head;
  logic                       rsp_push;
  logic                       rsp_pop;
  logic                       rsp_full;
  logic                       rsp_empty;
  logic [DATA_W:0]            rsp_wdata;
  logic [DATA_W:0]            rsp_head;
  logic [$clog2(RSP_DEPTH):0] unused_rsp_count;
  logic                       wait_done;
  logic                       res_done;
  logic                       tmo_fire;

  assign req_ready  = !cmd_full;
  assign cmd_push   = req_valid && req_ready;
  // Issue only when the result FIFO can take the eventual writeback.
  assign cmd_pop    = (state == S_IDLE) && !cmd_empty && !rsp_full;
  assign rsp_valid  = !rsp_empty;
  assign rsp_pop    = rsp_valid && rsp_ready;
  assign rsp_data   = rsp_head[DATA_W-1:0];
  assign rsp_err    = rsp_head[DATA_W];
  assign busy       = (state != S_IDLE);
  assign alu_csr_in = csr_in;

  assign res_done  = (state == S_COMPUTE) && alu_csr_out[FU_CSR_RES];
  assign wait_done = ((state == S_W_OP1) && alu_csr_out[FU_CSR_PROT]) ||
                     ((state == S_W_OP2) && alu_csr_out[FU_CSR_OP1])  ||
                     res_done;

`ifdef FU_ALU_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);

  logic [TW-1:0] tmo_cnt;
  logic          waiting;

  assign waiting  = (state == S_W_OP1) || (state == S_W_OP2) || (state == S_COMPUTE);
  assign tmo_fire = waiting && !wait_done && (tmo_cnt == TW'(TMO_CYC - 1));

  // Counter restarts whenever the FSM leaves a wait state.
  always_ff @(posedge clk) begin
    if (reset || !waiting || wait_done || tmo_fire) tmo_cnt <= '0;
    else                                            tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign rsp_push  = res_done || tmo_fire;
  assign rsp_wdata = tmo_fire ? {1'b1, {DATA_W{1'b0}}} : {1'b0, alu_op3};
`else
  logic unused_tmo_cfg;

  assign unused_tmo_cfg = (TMO_CYC > 0);
  assign tmo_fire       = 1'b0;
  assign rsp_push       = res_done;
  assign rsp_wdata      = {1'b0, alu_op3};
`endif

  fu_sync_fifo #(.W(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_push),
    .push_data ({req_aluop, req_op1, req_op2}),
    .pop       (cmd_pop),
    .pop_data  (cmd_head),
    .full      (cmd_full),
    .empty     (cmd_empty),
    .count     (cmd_count)
  );

  fu_sync_fifo #(.W(DATA_W + 1), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rsp_push),
    .push_data (rsp_wdata),
    .pop       (rsp_pop),
    .pop_data  (rsp_head),
    .full      (rsp_full),
    .empty     (rsp_empty),
    .count     (unused_rsp_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      csr_in    <= FU_CSR_IN_IDLE;
      alu_aluop <= '0;
      alu_op1   <= '0;
      alu_op2   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          csr_in <= FU_CSR_IN_IDLE;
          if (cmd_pop) begin
            {alu_aluop, alu_op1, alu_op2} <= cmd_head;
            state <= S_W_OP1;
          end
        end
        S_W_OP1: begin
          if (alu_csr_out[FU_CSR_PROT]) begin
            csr_in[FU_CSR_OP1] <= 1'b1;
            state <= S_L_OP1;
          end
        end
        S_L_OP1: begin
          csr_in[FU_CSR_OP1] <= 1'b0;
          state <= S_W_OP2;
        end
        S_W_OP2: begin
          if (alu_csr_out[FU_CSR_OP1]) begin
            csr_in[FU_CSR_OP2] <= 1'b1;
            state <= S_L_OP2;
          end
        end
        S_L_OP2: begin
          csr_in[FU_CSR_OP2]  <= 1'b0;
          csr_in[FU_CSR_PROT] <= 1'b0;
          state <= S_COMPUTE;
        end
        S_COMPUTE: begin
          if (alu_csr_out[FU_CSR_RES]) begin
            csr_in[FU_CSR_PROT] <= 1'b1;
            state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          csr_in[FU_CSR_PROT] <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          csr_in <= FU_CSR_IN_IDLE;
          state  <= S_IDLE;
        end
      endcase
      // Watchdog abort overrides whatever the wait state would have done.
      if (tmo_fire) begin
        csr_in <= FU_CSR_IN_IDLE;
        state  <= S_RELEASE;
      end
    end
  end

endmodule

// File: tb/tb_fu_alu_queue.sv
// Scoreboard bench for fu_alu_queue with a reactive model of the external ALU CSR handshake.
module tb_fu_alu_queue;

  localparam int DATA_W    = 32;
  localparam int ALUOP_W   = 4;
  localparam int CMD_DEPTH = 4;
  localparam int RSP_DEPTH = 2;
  localparam int TMO_CYC   = 16;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_aluop;
  logic [31:0]       req_op1;
  logic [31:0]       req_op2;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_err;
  logic [3:0]        alu_aluop;
  logic [31:0]       alu_op1;
  logic [31:0]       alu_op2;
  logic [31:0]       alu_op3;
  logic [2:0]        alu_csr_out;
  logic [2:0]        alu_csr_in;
  logic              busy;
  logic [2:0]        cmd_count;

  int                pass_cnt = 0;
  int                chk_cnt  = 0;
  logic [32:0]       exp_q[$];
  logic [2:0]        csr_trace[$];
  bit                trace_en = 1'b0;
  logic [2:0]        csr_last = 3'b001;
  bit                stall_op = 1'b0;
  bit                stall_res = 1'b0;

  fu_alu_queue #(
    .DATA_W(DATA_W), .ALUOP_W(ALUOP_W), .CMD_DEPTH(CMD_DEPTH),
    .RSP_DEPTH(RSP_DEPTH), .TMO_CYC(TMO_CYC)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_aluop(req_aluop),
    .req_op1(req_op1), .req_op2(req_op2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_aluop(alu_aluop), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op3(alu_op3),
    .alu_csr_out(alu_csr_out), .alu_csr_in(alu_csr_in),
    .busy(busy), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail_bound(input string name);
    chk_cnt++;
    $display("FAIL %s: cycle bound expired before the awaited event", name);
  endtask

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return 32'hdead_beef;
    endcase
  endfunction

  // External ALU: each ready/valid flag rises a few cycles after the FSM starts waiting for it.
  initial begin : alu_model
    int phase;
    int dly;
    phase = 0;
    dly = 0;
    alu_csr_out = 3'b000;
    alu_op3 = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        phase = 0; dly = 0; alu_csr_out = 3'b000;
      end else begin
        case (phase)
          0: if (alu_csr_in[1]) begin
               alu_csr_out[0] = 1'b0; dly = 0; phase = 1;
             end else if (busy && alu_csr_in == 3'b001 && !stall_op) begin
               if (dly >= 2) alu_csr_out[0] = 1'b1; else dly++;
             end
          1: if (alu_csr_in[2]) begin
               alu_csr_out[1] = 1'b0; dly = 0; phase = 2;
             end else if (!stall_op) begin
               if (dly >= 2) alu_csr_out[1] = 1'b1; else dly++;
             end
          default: if (alu_csr_in[0]) begin
               alu_csr_out[2] = 1'b0; dly = 0; phase = 0;
             end else if (!stall_res) begin
               if (dly >= 2) begin
                 alu_op3 = alu_f(alu_aluop, alu_op1, alu_op2);
                 alu_csr_out[2] = 1'b1;
               end else dly++;
             end
        endcase
      end
    end
  end

  initial begin : monitor
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!reset && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL rsp_unexpected: got err=%0b data=%0h, no result expected", rsp_err, rsp_data);
        end else begin
          e = exp_q.pop_front();
          check("rsp_err_data", {rsp_err, rsp_data}, e);
        end
      end
    end
  end

  initial begin : csr_tracer
    forever begin
      @(negedge clk);
      if (trace_en && alu_csr_in !== csr_last) csr_trace.push_back(alu_csr_in);
      csr_last = alu_csr_in;
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [32:0] e);
    int n;
    n = 0;
    req_aluop = op; req_op1 = a; req_op2 = b; req_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 200) begin
        fail_bound("send_accept");
        req_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    exp_q.push_back(e);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 || busy) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        fail_bound(name);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin : stim
    logic [2:0]  exp_tr [7];
    logic [3:0]  v_op  [5];
    logic [31:0] v_a   [5];
    logic [31:0] v_b   [5];
    logic [31:0] v_r   [5];
    logic [3:0]  f_op  [6];
    logic [31:0] f_a   [6];
    logic [31:0] f_b   [6];
    logic [31:0] f_r   [6];
    int n;

    exp_tr = '{3'b011, 3'b001, 3'b101, 3'b000, 3'b001, 3'b000, 3'b001};
    v_op = '{OP_SUB, OP_SUB, OP_AND, OP_OR, OP_XOR};
    v_a  = '{32'd100, 32'd0, 32'hffff_0000, 32'ha5a5_0000, 32'ha5a5_a5a5};
    v_b  = '{32'd30, 32'd1, 32'h1234_5678, 32'h0000_5a5a, 32'hffff_ffff};
    v_r  = '{32'd70, 32'hffff_ffff, 32'h1234_0000, 32'ha5a5_5a5a, 32'h5a5a_5a5a};
    f_op = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADD};
    f_a  = '{32'd1, 32'd10, 32'h0000_f0f0, 32'h0000_0f00, 32'hffff_ffff, 32'hffff_ffff};
    f_b  = '{32'd2, 32'd3, 32'h0000_ff00, 32'h0000_00f0, 32'h0000_0001, 32'h0000_0001};
    f_r  = '{32'd3, 32'd7, 32'h0000_f000, 32'h0000_0ff0, 32'hffff_fffe, 32'h0000_0000};

    reset = 1'b1; req_valid = 1'b0; req_aluop = '0; req_op1 = '0; req_op2 = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_csr_in", alu_csr_in, 3'b001);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_count", cmd_count, 3'd0);
    check("rst_rsp_data", {rsp_err, rsp_data}, 33'd0);
    check("rst_alu_ops", {alu_aluop, alu_op1, alu_op2}, 68'd0);

    // Single ADD with the CSR sequence recorded.
    csr_last = alu_csr_in;
    trace_en = 1'b1;
    send(OP_ADD, 32'd5, 32'd7, {1'b0, 32'd12});
    wait_drain("single_drain");
    repeat (3) @(posedge clk);
    #1 trace_en = 1'b0;
    check("single_trace_len", csr_trace.size(), 7);
    for (int i = 0; i < 7; i++)
      if (i < csr_trace.size()) check($sformatf("single_csr_in[%0d]", i), csr_trace[i], exp_tr[i]);
    check("single_ops_held", {alu_aluop, alu_op1, alu_op2}, {OP_ADD, 32'd5, 32'd7});

    // Back-to-back mixed opcodes.
    for (int i = 0; i < 5; i++) send(v_op[i], v_a[i], v_b[i], {1'b0, v_r[i]});
    wait_drain("multi_drain");

    // Command FIFO full while the ALU is stalled.
    stall_op = 1'b1;
    for (int i = 0; i < 5; i++) send(f_op[i], f_a[i], f_b[i], {1'b0, f_r[i]});
    check("full_req_ready", req_ready, 1'b0);
    check("full_cmd_count", cmd_count, 3'd4);
    check("full_busy", busy, 1'b1);
    req_aluop = f_op[5]; req_op1 = f_a[5]; req_op2 = f_b[5]; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_hold_ready", req_ready, 1'b0);
      check("full_hold_count", cmd_count, 3'd4);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    stall_op = 1'b0;
    send(f_op[5], f_a[5], f_b[5], {1'b0, f_r[5]});
    wait_drain("full_drain");

    // Result FIFO back-pressure holds the third op in IDLE.
    rsp_ready = 1'b0;
    send(OP_ADD, 32'd1, 32'd1, {1'b0, 32'd2});
    send(OP_ADD, 32'd2, 32'd2, {1'b0, 32'd4});
    send(OP_ADD, 32'd3, 32'd3, {1'b0, 32'd6});
    repeat (60) @(posedge clk);
    #1;
    check("bp_busy_idle", busy, 1'b0);
    check("bp_cmd_count", cmd_count, 3'd1);
    check("bp_rsp_head", {rsp_valid, rsp_data}, {1'b1, 32'd2});
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    check("bp_issue_after_pop", busy, 1'b1);
    check("bp_cmd_count_after", cmd_count, 3'd0);
    rsp_ready = 1'b1;
    wait_drain("bp_drain");

    // Reset in COMPUTE with two commands still queued.
    stall_res = 1'b1;
    send(OP_ADD, 32'd11, 32'd22, {1'b0, 32'd33});
    send(OP_SUB, 32'd50, 32'd8, {1'b0, 32'd42});
    send(OP_XOR, 32'd15, 32'd3, {1'b0, 32'd12});
    n = 0;
    while (!(busy && alu_csr_in == 3'b000)) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        fail_bound("rst_mid_compute_wait");
        break;
      end
    end
    check("rstmid_queued", cmd_count, 3'd2);
    @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("rstmid_csr_in", alu_csr_in, 3'b001);
    check("rstmid_cmd_count", cmd_count, 3'd0);
    check("rstmid_rsp_valid", rsp_valid, 1'b0);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_req_ready", req_ready, 1'b1);
    reset = 1'b0;
    stall_res = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("rstmid_no_result", {rsp_valid, busy}, 2'b00);

`ifdef FU_ALU_TIMEOUT_EN
    // Result-valid never arrives: the watchdog aborts with an error result.
    stall_res = 1'b1;
    send(OP_ADD, 32'd9, 32'd9, {1'b1, 32'd0});
    n = 0;
    while (!(busy && alu_csr_in == 3'b000)) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        fail_bound("tmo_compute_wait");
        break;
      end
    end
    n = 0;
    while (!rsp_valid) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        fail_bound("tmo_result_wait");
        break;
      end
    end
    check("tmo_cycles", n, TMO_CYC);
    stall_res = 1'b0;
    wait_drain("tmo_drain");
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
